meta_intf_rr_distributor: RTL and testbench
===========================================

META_INTF_RR_DISTRIBUTOR -- requirements
Module: meta_intf_rr_distributor

Interface
REQ-001 SHALL have parameter N_INTERFACES, default N_STRM_AXI, number of output interfaces (1..16).
REQ-002 SHALL have parameter STYPE, default logic[63:0], type of the data field of every interface.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port intf_in  metaIntf.s  STYPE  single input stream (valid/ready/data).
REQ-006 SHALL have port intf_out[N_INTERFACES]  metaIntf.m  STYPE  output streams (valid/ready/data).
REQ-007 SHALL have port beat_cnt  output  N_INTERFACES x 32  per-output accepted-beat counters, present only under LIBSTF_DIST_CNT_EN.

Function
REQ-008 SHALL hold one registered slot (valid bit, data) per output; intf_out[i].valid/data are driven directly from slot i.
REQ-009 SHALL treat slot i as accepting in a cycle when slot i is empty or intf_out[i].ready is high.
REQ-010 SHALL drive intf_in.ready combinationally high when at least one slot is accepting, with no dependence on intf_in.valid.
REQ-011 SHALL keep a round-robin pointer rr_next, width max(1, clog2(N_INTERFACES)), reset to 0.
REQ-012 SHALL select target = first accepting index scanning rr_next, rr_next+1, ..., wrapping modulo N_INTERFACES.
REQ-013 SHALL, on intf_in.valid & intf_in.ready, load data into slot target, set its valid, and set rr_next to (target+1) mod N_INTERFACES.
REQ-014 SHALL leave rr_next unchanged in cycles with no input transfer.
REQ-015 SHALL clear slot i valid when intf_out[i].ready is high and slot i is not loaded in the same cycle.
REQ-016 SHALL, on simultaneous drain and load of slot i, keep valid high and present the new data next cycle (no bubble).
REQ-017 SHALL have a latency of exactly one cycle from input transfer to output valid, and sustain one input beat per cycle.
REQ-018 SHALL hold intf_out[i].data stable while intf_out[i].valid is high and ready is low (AXI-stream rule).
REQ-019 SHALL deliver each input beat to exactly one output; no loss, no duplication, in-order per output.
REQ-020 SHALL, with all slots full and all readies low, hold intf_in.ready low indefinitely and lose nothing.
REQ-021 SHALL, for N_INTERFACES = 1, behave as a single-entry register slice with rr_next constant 0.

Reset
REQ-022 SHALL, while rst is high, clear all slot valids, rr_next, and beat_cnt (when present) at the next clock edge.
REQ-023 SHALL drive intf_in.ready low and all intf_out[i].valid low while rst is high.
REQ-024 SHALL discard slot contents on reset mid-operation; slot data registers need no reset.
REQ-025 SHALL accept input on the first cycle after rst deasserts.

Configuration
REQ-026 SHALL, with LIBSTF_DIST_CNT_EN defined, increment beat_cnt[i] by 1 on each intf_out[i] valid&ready transfer, wrapping 2^32-1 -> 0.
REQ-027 SHALL, without LIBSTF_DIST_CNT_EN, omit beat_cnt port and counters entirely; all other behaviour identical.

Verification (N_INTERFACES = 4, STYPE 64-bit)
REQ-028 SHALL cover: all readies high, input beats 0x10..0x17 back-to-back -> outputs 0,1,2,3,0,1,2,3 receive them in order, one cycle later each.
REQ-029 SHALL cover: intf_out[1].ready low, slot 1 full, rr_next=1, beat 0xA -> 0xA goes to output 2, rr_next becomes 3.
REQ-030 SHALL cover: all readies low, 5 beats offered -> 4 accepted (outputs 0..3), intf_in.ready low thereafter, 5th beat held and accepted after intf_out[0].ready rises.
REQ-031 SHALL cover: slot 0 drained and reloaded same cycle -> intf_out[0].valid stays high, new data next cycle.
REQ-032 SHALL cover: rst pulsed with 3 slots full -> all valids 0, rr_next 0, beat_cnt 0; first post-reset beat goes to output 0.
REQ-033 SHALL cover (LIBSTF_DIST_CNT_EN): 1000 random beats with random readies -> sum of beat_cnt equals 1000 and matches scoreboard per output.

Source files
------------

// File: rtl/meta_intf_rr_distributor.sv
// Round-robin distributor: one input stream fanned out beat-by-beat to N registered output slots.
// Optional per-output beat counters are built when LIBSTF_DIST_CNT_EN is defined.
module meta_intf_rr_distributor #(
  parameter int  N_INTERFACES = 4,
  parameter type STYPE        = logic [63:0]
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    intf_in_valid,
  output logic                    intf_in_ready,
  input  STYPE                    intf_in_data,
  output logic [N_INTERFACES-1:0] intf_out_valid,
  input  logic [N_INTERFACES-1:0] intf_out_ready,
  output STYPE                    intf_out_data [N_INTERFACES]
`ifdef LIBSTF_DIST_CNT_EN
  ,
  output logic [31:0]             beat_cnt [N_INTERFACES]
`endif
);

  localparam int PW = (N_INTERFACES > 1) ? $clog2(N_INTERFACES) : 1;

  logic [N_INTERFACES-1:0] slot_valid_r;
  STYPE                    slot_data_r [N_INTERFACES];
  logic [PW-1:0]           rr_next_r;
  logic [N_INTERFACES-1:0] accepting_s;
  logic [PW-1:0]           target_s;
  logic [PW-1:0]           rr_after_s;
  logic                    load_s;

  // A slot can take a beat when it is empty or is being drained this cycle.
  always_comb begin
    accepting_s = ~slot_valid_r | intf_out_ready;
  end

  // Scan backwards from rr_next+N-1 so the last hit is the first accepting index from rr_next.
  always_comb begin
    target_s = rr_next_r;
    for (int k = N_INTERFACES - 1; k >= 0; k--) begin
      target_s = accepting_s[(int'(rr_next_r) + k) % N_INTERFACES]
               ? PW'((int'(rr_next_r) + k) % N_INTERFACES) : target_s;
    end
  end

  // Handshake and pointer advance; outputs are forced idle while reset is held.
  always_comb begin
    intf_in_ready  = (|accepting_s) & ~rst;
    load_s         = intf_in_valid & intf_in_ready;
    intf_out_valid = slot_valid_r & {N_INTERFACES{~rst}};
    rr_after_s     = (int'(target_s) == N_INTERFACES - 1) ? PW'(0) : target_s + PW'(1);
    intf_out_data  = slot_data_r;
  end

  // Slot valid bits and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_r <= '0;
      rr_next_r    <= '0;
    end else begin
      if (load_s) begin
        rr_next_r <= rr_after_s;
      end else begin
        rr_next_r <= rr_next_r;
      end
      for (int i = 0; i < N_INTERFACES; i++) begin
        // A same-cycle load wins over a drain, so the slot never bubbles.
        if (load_s && (target_s == PW'(i))) begin
          slot_valid_r[i] <= 1'b1;
        end else if (intf_out_ready[i]) begin
          slot_valid_r[i] <= 1'b0;
        end else begin
          slot_valid_r[i] <= slot_valid_r[i];
        end
      end
    end
  end

  // Slot payloads: no reset needed, contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_INTERFACES; i++) begin
      if (load_s && (target_s == PW'(i))) begin
        slot_data_r[i] <= intf_in_data;
      end else begin
        slot_data_r[i] <= slot_data_r[i];
      end
    end
  end

`ifdef LIBSTF_DIST_CNT_EN
  // Per-output accepted-beat counters, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_INTERFACES; i++) begin
      if (rst) begin
        beat_cnt[i] <= 32'd0;
      end else if (intf_out_valid[i] && intf_out_ready[i]) begin
        beat_cnt[i] <= beat_cnt[i] + 32'd1;
      end else begin
        beat_cnt[i] <= beat_cnt[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_meta_intf_rr_distributor.sv
// Self-checking bench for meta_intf_rr_distributor (N_INTERFACES=4, 64-bit data).
// Directed vector table, reset sequence, then a random phase against a per-output scoreboard.
module tb_meta_intf_rr_distributor;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = 64'd0;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready = '0;
  logic [63:0]   out_data [N];
`ifdef LIBSTF_DIST_CNT_EN
  logic [31:0]   beat_cnt [N];
`endif

  meta_intf_rr_distributor #(.N_INTERFACES(N), .STYPE(logic [63:0])) dut (
    .clk            (clk),
    .rst            (rst),
    .intf_in_valid  (in_valid),
    .intf_in_ready  (in_ready),
    .intf_in_data   (in_data),
    .intf_out_valid (out_valid),
    .intf_out_ready (out_ready),
    .intf_out_data  (out_data)
`ifdef LIBSTF_DIST_CNT_EN
    ,
    .beat_cnt       (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic [3:0]  rdy;
    int          tgt;
    logic        exp_rdy;
  } vec_t;

  vec_t        tbl [$];
  logic [63:0] q [N][$];
  int          cnt [N];
  int          model_rr = 0;
  int          accepted = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [63:0] d, input logic [3:0] rdy,
                              input int tgt, input logic exp_rdy);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.tgt = tgt; r.exp_rdy = exp_rdy;
    return r;
  endfunction

  task automatic do_cycle(input vec_t vv, input string name);
    logic [63:0] exp_d;
    @(negedge clk);
    in_valid  = vv.v;
    in_data   = vv.d;
    out_ready = vv.rdy;
    #1;
    chk({name, " in_ready"}, 64'(in_ready), 64'(vv.exp_rdy));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s valid%0d", name, i), 64'(out_valid[i]), 64'(q[i].size() != 0));
      if (q[i].size() != 0) begin
        exp_d = q[i][0];
        chk($sformatf("%s data%0d", name, i), out_data[i], exp_d);
        if (vv.rdy[i]) begin
          exp_d = q[i].pop_front();
          cnt[i]++;
        end
      end
    end
    if (vv.v && vv.exp_rdy && vv.tgt >= 0) begin
      q[vv.tgt].push_back(vv.d);
      model_rr = (vv.tgt + 1) % N;
      accepted++;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = '0; in_data = 64'hdead;
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("rst out_valid post-edge", 64'(out_valid), 64'd0);
`ifdef LIBSTF_DIST_CNT_EN
    for (int i = 0; i < N; i++) chk($sformatf("rst beat_cnt%0d", i), 64'(beat_cnt[i]), 64'd0);
`endif
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      cnt[i] = 0;
    end
    model_rr = 0;
    accepted = 0;
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    vec_t vv;
    logic [N-1:0] acc;
    int  tgt;
    int  cyc;
    int  sum;

    // Back-to-back with all readies high: round-robin 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) tbl.push_back(mk(1'b1, 64'h10 + 64'(k), 4'hF, k % 4, 1'b1));
    tbl.push_back(mk(1'b0, 64'h0, 4'hF, -1, 1'b1));
    // All readies low: four accepted, fifth stalled until output 0 drains.
    tbl.push_back(mk(1'b1, 64'h20, 4'h0, 0, 1'b1));
    tbl.push_back(mk(1'b1, 64'h21, 4'h0, 1, 1'b1));
    tbl.push_back(mk(1'b1, 64'h22, 4'h0, 2, 1'b1));
    tbl.push_back(mk(1'b1, 64'h23, 4'h0, 3, 1'b1));
    tbl.push_back(mk(1'b1, 64'h24, 4'h0, -1, 1'b0));
    tbl.push_back(mk(1'b1, 64'h24, 4'h0, -1, 1'b0));
    tbl.push_back(mk(1'b1, 64'h24, 4'h1, 0, 1'b1));   // slot 0 drained and reloaded together
    // Slot 1 full and stalled with rr_next=1: the beat skips to output 2.
    tbl.push_back(mk(1'b1, 64'h0A, 4'b1101, 2, 1'b1));
    tbl.push_back(mk(1'b0, 64'h0, 4'hF, -1, 1'b1));
    tbl.push_back(mk(1'b0, 64'h0, 4'hF, -1, 1'b1));
    // Fill three slots before the mid-operation reset (rr_next=3 here).
    tbl.push_back(mk(1'b1, 64'h30, 4'h0, 3, 1'b1));
    tbl.push_back(mk(1'b1, 64'h31, 4'h0, 0, 1'b1));
    tbl.push_back(mk(1'b1, 64'h32, 4'h0, 1, 1'b1));

    do_reset();
    for (int k = 0; k < tbl.size(); k++) do_cycle(tbl[k], $sformatf("vec%0d", k));

    do_reset();
    do_cycle(mk(1'b1, 64'h40, 4'hF, 0, 1'b1), "post_rst");
    do_cycle(mk(1'b0, 64'h0, 4'hF, -1, 1'b1), "post_rst_idle");

    // Random traffic with random readies, expectations from the scoreboard model.
    cyc = 0;
    while (accepted < 1001 && cyc < 20000) begin
      vv.v   = ($urandom_range(0, 3) != 0);
      vv.d   = {$urandom, $urandom};
      vv.rdy = 4'($urandom);
      for (int i = 0; i < N; i++) acc[i] = (q[i].size() == 0) || vv.rdy[i];
      tgt = -1;
      for (int k = 0; k < N; k++) begin
        if (tgt < 0 && acc[(model_rr + k) % N]) tgt = (model_rr + k) % N;
      end
      vv.exp_rdy = (acc != '0);
      vv.tgt     = tgt;
      do_cycle(vv, "rand");
      cyc++;
    end
    chk("rand beats accepted", 64'(accepted), 64'd1001);
    do_cycle(mk(1'b0, 64'h0, 4'hF, -1, 1'b1), "drain");
    do_cycle(mk(1'b0, 64'h0, 4'hF, -1, 1'b1), "drain_idle");
`ifdef LIBSTF_DIST_CNT_EN
    #1;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("beat_cnt%0d", i), 64'(beat_cnt[i]), 64'(cnt[i]));
      sum += int'(beat_cnt[i]);
    end
    chk("beat_cnt sum", 64'(sum), 64'(accepted));
`else
    sum = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
